// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: loader FSM state enum, RV32 NOP encoding, byte parity helper.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // addi x0, x0, 0 : returned on reads that cannot be served
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Even parity: the stored bit makes the 9-bit lane XOR to zero.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/imem_bank.sv
// Byte-lane synchronous RAM, write-first on same-address read/write, no reset.
// Latency: 1 cycle read (rd_dat updates only on cycles with rd_en).
// Backpressure: none; rd_dat holds its value while rd_en is low.
//
// Ports:
//   clk            clock
//   wr_en [NL]     per-lane write enables
//   wr_addr/wr_dat write word address / lane-packed data
//   rd_en/rd_addr  read strobe / word address
//   rd_dat         registered read data (same-word writes forwarded per lane)
module imem_bank #(
  parameter int LW = 8,   // bits per lane (8, or 9 with parity)
  parameter int NL = 4,   // lanes per word
  parameter int AW = 12   // word address bits
) (
  input  logic             clk,
  input  logic [NL-1:0]    wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NL*LW-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [NL*LW-1:0] rd_dat
);

  localparam int MEM_NUM = 2**AW;

  logic [NL*LW-1:0] mem [MEM_NUM];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (wr_en[k]) begin
        mem[wr_addr][k*LW +: LW] <= wr_dat[k*LW +: LW];
      end
      // Write-first: a lane written this cycle to the word being read
      // returns the new lane, the rest of the word returns stored data.
      if (rd_en) begin
        rd_dat[k*LW +: LW] <= (wr_en[k] && (wr_addr == rd_addr)) ?
                              wr_dat[k*LW +: LW] : mem[rd_addr][k*LW +: LW];
      end
    end
  end

endmodule

// File: rtl/imem_loader_bank.sv
// Instruction memory: registered IF read port, byte-enable write port, streaming boot loader.
// Latency: read data/valid/err 1 cycle after ren; writes and loader words land at the edge.
// Backpressure: ren=0 stalls (outputs hold); loader accepts a word every LOAD cycle (load_ready_o).
//
// Optional feature: define IMEM_PARITY_EN to store and check one even-parity bit per byte.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   wen, w_addr_i, w_data_i, w_be_i   CPU/debug byte-enable write (ignored while loading)
//   ren, r_addr_i                 read request, byte address
//   r_data_o, r_valid_o, r_err_o  read data, updated-this-cycle, address/parity error
//   load_start_i                  (re)start loading at word 0 (ignored while loading)
//   load_valid_i, load_data_i, load_last_i   loader word stream
//   load_ready_o, load_done_o     loader accepting words / load finished (sticky)
module imem_loader_bank
  import imem_pkg::*;
#(
  parameter int          DW        = 32,
  parameter int          AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA  = RV_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [31:0]     w_addr_i,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_be_i,
  input  logic            ren,
  input  logic [31:0]     r_addr_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_valid_o,
  output logic            r_err_o,
  input  logic            load_start_i,
  input  logic            load_valid_i,
  input  logic [DW-1:0]   load_data_i,
  input  logic            load_last_i,
  output logic            load_ready_o,
  output logic            load_done_o
);

  localparam int NL = DW / 8;
`ifdef IMEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam logic [DW-1:0] ERR_W = DW'(ERR_DATA);

  // ---------------- address decode ----------------
  logic [31:0]   r_off, w_off;
  logic          r_bad, w_bad;
  logic [AW-1:0] r_word, w_word;

  assign r_off  = r_addr_i - BASE_ADDR;
  assign w_off  = w_addr_i - BASE_ADDR;
  assign r_bad  = (r_addr_i[1:0] != 2'b00) || ((r_off >> (AW + 2)) != 32'd0);
  assign w_bad  = (w_addr_i[1:0] != 2'b00) || ((w_off >> (AW + 2)) != 32'd0);
  assign r_word = r_off[AW+1:2];
  assign w_word = w_off[AW+1:2];

  // ---------------- loader FSM ----------------
  load_state_t   state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      load_ready_o <= 1'b0;
      load_done_o  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_start_i) begin
            state        <= LOAD;
            ptr          <= '0;
            load_ready_o <= 1'b1;
            load_done_o  <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid_i) begin
            if (load_last_i || (ptr == {AW{1'b1}})) begin
              state        <= DONE;
              load_ready_o <= 1'b0;
              load_done_o  <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          load_ready_o <= 1'b0;
          load_done_o  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- write port arbitration ----------------
  // The loader owns the write port for every LOAD cycle, valid or not.
  logic [NL-1:0]    bank_wr_en;
  logic [AW-1:0]    bank_wr_addr;
  logic [DW-1:0]    wr_bytes;
  logic [NL*LW-1:0] bank_wr_dat;

  always_comb begin
    bank_wr_en   = '0;
    bank_wr_addr = w_word;
    wr_bytes     = w_data_i;
    if (state == LOAD) begin
      bank_wr_addr = ptr;
      wr_bytes     = load_data_i;
      if (load_valid_i) bank_wr_en = '1;
    end else if (wen && !w_bad) begin
      bank_wr_en = w_be_i;
    end
  end

  always_comb begin
    bank_wr_dat = '0;
    for (int k = 0; k < NL; k++) begin
`ifdef IMEM_PARITY_EN
      bank_wr_dat[k*LW +: LW] = {byte_parity(wr_bytes[k*8 +: 8]), wr_bytes[k*8 +: 8]};
`else
      bank_wr_dat[k*LW +: LW] = wr_bytes[k*8 +: 8];
`endif
    end
  end

  // ---------------- array ----------------
  logic [NL*LW-1:0] bank_rd_dat;

  imem_bank #(.LW(LW), .NL(NL), .AW(AW)) u_bank (
    .clk     (clk),
    .wr_en   (bank_wr_en),
    .wr_addr (bank_wr_addr),
    .wr_dat  (bank_wr_dat),
    .rd_en   (ren && !r_bad),
    .rd_addr (r_word),
    .rd_dat  (bank_rd_dat)
  );

  // ---------------- read side ----------------
  // rd_src_q marks that the array register holds a real read since reset,
  // so the output reads 0 after reset despite the unreset array register.
  // All select state only moves with ren, which gives the stall hold.
  logic rd_src_q, rd_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_o <= 1'b0;
      rd_src_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      r_valid_o <= ren;
      if (ren) begin
        rd_src_q <= 1'b1;
        rd_err_q <= r_bad;
      end
    end
  end

  logic [DW-1:0] rd_bytes;
  logic          par_err;

  always_comb begin
    rd_bytes = '0;
    par_err  = 1'b0;
    for (int k = 0; k < NL; k++) begin
      rd_bytes[k*8 +: 8] = bank_rd_dat[k*LW +: 8];
`ifdef IMEM_PARITY_EN
      par_err = par_err | (^bank_rd_dat[k*LW +: LW]);
`endif
    end
  end

  assign r_data_o = rd_err_q ? ERR_W : (rd_src_q ? rd_bytes : '0);
  assign r_err_o  = rd_err_q | (rd_src_q & par_err);

endmodule
